// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer: push/pop/flush with an occupancy count.
// Flush wins over push and pop; a push while full is accepted only alongside a pop.
module fetch_fifo
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] din,
    output logic [63:0] head,
    output logic [1:0]  count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    // With two slots the free slot is the head slot when empty or full, the other one otherwise.
    assign wr_ptr  = rd_ptr ^ count[0];
    assign head    = (count == 2'd0) ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= fetch_entry_t'(din);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: single-outstanding memory request FSM feeding a 2-entry buffer.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] PC_out,
    output logic [31:0] Instr_out,
    output logic        valid_out
);

    fetch_state_t state, state_nx;
    logic [31:0]  fetch_pc, fetch_pc_nx;
    logic [31:0]  req_pc, req_pc_nx;
    logic [31:0]  redirect_aligned;
    logic         push;
    logic         pop;
    logic [63:0]  head;
    logic [1:0]   count;
    fetch_entry_t push_entry;

    assign redirect_aligned = redirect_pc & ~32'd3;
    assign push_entry       = '{pc: req_pc, instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            req_pc   <= req_pc_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        req_pc_nx   = req_pc;
        push        = 1'b0;
        // Space check counts the in-flight response so a full buffer never overflows.
        imem_req    = rst && (state == FETCH) && !redirect &&
                      ((32'(count) + 32'(state != FETCH)) < FIFO_DEPTH);
        imem_addr   = fetch_pc;

        case (state)
            FETCH: begin
                if (redirect) begin
                    fetch_pc_nx = redirect_aligned;
                end else if (imem_req && imem_gnt) begin
                    state_nx    = WAIT;
                    req_pc_nx   = fetch_pc;
                    fetch_pc_nx = fetch_pc + 32'd4;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_nx = redirect_aligned;
                    state_nx    = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    push     = 1'b1;
                    state_nx = FETCH;
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_nx = redirect_aligned;
                end
                if (imem_rvalid) begin
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
    end

    assign valid_out = (count != 2'd0);
    assign pop       = valid_out && !stall && !redirect;
    assign PC_out    = head[63:32];
    assign Instr_out = head[31:0];

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a latency-programmable memory responder (instr = addr + 0x1300_0000).
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] PC_out;
    logic [31:0] Instr_out;
    logic        valid_out;

    int          nvec = 0;
    int          nerr = 0;
    int          lat  = 1;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = '0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .PC_out      (PC_out),
        .Instr_out   (Instr_out),
        .valid_out   (valid_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; rvalid follows a grant after lat cycles.
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        #1;
        g  = imem_req && imem_gnt;
        ga = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr + 32'h1300_0000;
                pend        = 1'b0;
            end
        end
        if (g) begin
            if (lat == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ga + 32'h1300_0000;
            end else begin
                pend  = 1'b1;
                pcnt  = lat - 1;
                paddr = ga;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; stall = 1'b0;

        // reset state
        tick(); tick();
        #1;
        chk("rst_req",   {31'b0, imem_req},  32'd0);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_pc",    PC_out,             32'd0);
        chk("rst_instr", Instr_out,          32'd0);

        // streaming after reset release: 0, 4, 8
        rst = 1'b1; #1;
        chk("k0_req",  {31'b0, imem_req}, 32'd1);
        chk("k0_addr", imem_addr,         32'h0);
        tick(); #1;
        chk("k1_req",   {31'b0, imem_req},  32'd0);
        chk("k1_valid", {31'b0, valid_out}, 32'd0);
        tick(); #1;
        chk("k2_valid", {31'b0, valid_out}, 32'd1);
        chk("k2_pc",    PC_out,             32'h0);
        chk("k2_instr", Instr_out,          32'h1300_0000);
        chk("k2_addr",  imem_addr,          32'h4);
        tick(); #1;
        chk("k3_bubble", {31'b0, valid_out}, 32'd0);
        tick(); #1;
        chk("k4_pc",   PC_out,    32'h4);
        chk("k4_addr", imem_addr, 32'h8);
        tick(); tick(); #1;
        chk("k6_pc",    PC_out,    32'h8);
        chk("k6_instr", Instr_out, 32'h1300_0008);

        // reset again, then stall with memory streaming
        tick();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1; stall = 1'b1; #1;
        chk("s0_valid", {31'b0, valid_out}, 32'd0);
        chk("s0_addr",  imem_addr,          32'h0);
        tick(); tick(); #1;
        chk("s2_pc",   PC_out,           32'h0);
        chk("s2_req",  {31'b0, imem_req}, 32'd1);
        chk("s2_addr", imem_addr,        32'h4);
        tick(); #1;
        chk("s3_hold", PC_out, 32'h0);
        tick(); #1;
        chk("s4_full_req", {31'b0, imem_req},  32'd0);
        chk("s4_valid",    {31'b0, valid_out}, 32'd1);
        chk("s4_hold",     PC_out,             32'h0);
        tick();
        stall = 1'b0; #1;
        chk("s5_req", {31'b0, imem_req}, 32'd0);
        chk("s5_pc",  PC_out,            32'h0);
        tick(); #1;
        chk("s6_pc",    PC_out,    32'h4);
        chk("s6_instr", Instr_out, 32'h1300_0004);
        chk("s6_addr",  imem_addr, 32'h8);
        tick(); #1;
        chk("s7_bubble", {31'b0, valid_out}, 32'd0);
        tick(); #1;
        chk("s8_pc",   PC_out,    32'h8);
        chk("s8_addr", imem_addr, 32'hC);
        lat = 2;

        // redirect in WAIT, response arrives the cycle after
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
        chk("r9_req",   {31'b0, imem_req},  32'd0);
        chk("r9_valid", {31'b0, valid_out}, 32'd0);
        tick();
        redirect = 1'b0; #1;
        chk("r10_drop_req", {31'b0, imem_req},  32'd0);
        chk("r10_valid",    {31'b0, valid_out}, 32'd0);
        lat = 1;
        tick(); #1;
        chk("r11_req",   {31'b0, imem_req},  32'd1);
        chk("r11_addr",  imem_addr,          32'h100);
        chk("r11_valid", {31'b0, valid_out}, 32'd0);
        tick(); tick(); #1;
        chk("r13_pc",    PC_out,    32'h100);
        chk("r13_instr", Instr_out, 32'h1300_0100);
        chk("r13_addr",  imem_addr, 32'h104);

        // redirect coincident with rvalid
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
        chk("c14_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0; #1;
        chk("c15_req",   {31'b0, imem_req},  32'd1);
        chk("c15_addr",  imem_addr,          32'h200);
        chk("c15_valid", {31'b0, valid_out}, 32'd0);

        // address wrap at the top of memory
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        chk("w15_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0; #1;
        chk("w16_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); tick(); #1;
        chk("w18_pc",    PC_out,           32'hFFFF_FFFC);
        chk("w18_instr", Instr_out,        32'h12FF_FFFC);
        chk("w18_req",   {31'b0, imem_req}, 32'd1);
        chk("w18_addr",  imem_addr,        32'h0);
        lat = 2;

        // reset while WAIT, late response arrives during reset
        tick();
        rst = 1'b0; #1;
        chk("x19_req", {31'b0, imem_req}, 32'd0);
        tick(); #1;
        chk("x20_req",   {31'b0, imem_req},  32'd0);
        chk("x20_valid", {31'b0, valid_out}, 32'd0);
        chk("x20_pc",    PC_out,             32'd0);
        chk("x20_instr", Instr_out,          32'd0);
        lat = 1;
        tick();
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        chk("x21_req",   {31'b0, imem_req},  32'd1);
        chk("x21_addr",  imem_addr,          32'h0);
        chk("x21_valid", {31'b0, valid_out}, 32'd0);
        tick(); #1;
        chk("x22_ignored", {31'b0, valid_out}, 32'd0);
        tick(); #1;
        chk("x23_valid", {31'b0, valid_out}, 32'd1);
        chk("x23_pc",    PC_out,             32'h0);
        chk("x23_instr", Instr_out,          32'h1300_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
